// File: rtl/ctrl_sync_fifo_pkg.sv
// Shared constants for the control-word driven synchronous FIFO.
package ctrl_fifo_pkg;

    // Bit positions inside the CSR CONTROL word.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // Width of the CSR FIFO_LEVEL field; default width of the level output.
    localparam int CSR_LEVEL_WIDTH = 32;

endpackage

// File: rtl/ctrl_sync_fifo_if.sv
// Valid/ready write and read channels of the FIFO, bundled as one interface.
interface ctrl_sync_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Producer/consumer side: drives the write payload and read acceptance.
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    // FIFO side.
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/ctrl_sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     ACLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents survive reset and flush on purpose.
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ctrl_sync_fifo.sv
// First-word-fall-through FIFO gated by a CSR CONTROL word (EN / FLUSH),
// with registered level, empty/full flags and a sticky overflow flag.
module ctrl_sync_fifo
    import ctrl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int LEVEL_WIDTH = CSR_LEVEL_WIDTH
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [31:0]            CONTROL_i,
    ctrl_sync_fifo_if.slave        bus,
    output logic                   fifo_empty_o,
    output logic                   fifo_full_o,
    output logic [LEVEL_WIDTH-1:0] fifo_level_o,
    output logic                   overflow_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic          en;
    logic          flush;
    logic          unused_ctrl;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   level_q;
    logic          ptr_empty;
    logic          ptr_full;
    logic          push;
    logic          pop;
    logic [DATA_WIDTH-1:0] rd_data;

    assign en          = CONTROL_i[CTRL_EN_BIT];
    assign flush       = CONTROL_i[CTRL_FLUSH_BIT];
    assign unused_ctrl = ^CONTROL_i[31:2];

    // Extra MSB on each pointer distinguishes full from empty at equal index.
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Handshakes are masked during reset so every output shows its reset value.
    assign bus.s_ready = en && !flush && !ptr_full  && !ARESET;
    assign bus.m_valid = en && !flush && !ptr_empty && !ARESET;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.m_valid && bus.m_ready;

    assign fifo_empty_o = (level_q == '0);
    assign fifo_full_o  = (level_q == DEPTH_L);
    assign fifo_level_o = LEVEL_WIDTH'(level_q);
    assign bus.m_data   = rd_data;

    // Pointers and level: flush clears, otherwise follow the handshakes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Sticky overflow: a write attempt against a full, enabled FIFO.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            overflow_o <= 1'b0;
        end else if (flush) begin
            overflow_o <= 1'b0;
        end else if (bus.s_valid && en && ptr_full) begin
            overflow_o <= 1'b1;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .ACLK  (ACLK),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.s_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_ctrl_sync_fifo.sv
// Self-checking bench for ctrl_sync_fifo against a queue-based reference model.
module tb_ctrl_sync_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 32;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [31:0]   CONTROL_i;
    logic          fifo_empty_o;
    logic          fifo_full_o;
    logic [LW-1:0] fifo_level_o;
    logic          overflow_o;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: queue contents and sticky overflow.
    logic [DW-1:0] q[$];
    bit            ovf = 1'b0;

    ctrl_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    ctrl_sync_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .LEVEL_WIDTH (LW)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .CONTROL_i    (CONTROL_i),
        .bus          (bus),
        .fifo_empty_o (fifo_empty_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o)
    );

    always #5 ACLK = ~ACLK;

    function automatic bit exp_s_ready();
        return !ARESET && CONTROL_i[0] && !CONTROL_i[1] && (q.size() < DEPTH);
    endfunction

    function automatic bit exp_m_valid();
        return !ARESET && CONTROL_i[0] && !CONTROL_i[1] && (q.size() > 0);
    endfunction

    // Advance one clock edge, applying the FIFO rules to the model.
    task automatic tick();
        bit            do_push = 1'b0;
        bit            do_pop  = 1'b0;
        bit            do_flush;
        bit            set_ovf = 1'b0;
        logic [DW-1:0] wdat;
        do_flush = CONTROL_i[1];
        wdat     = bus.s_data;
        if (!do_flush && CONTROL_i[0]) begin
            set_ovf = bus.s_valid && (q.size() == DEPTH);
            do_push = bus.s_valid && (q.size() < DEPTH);
            do_pop  = bus.m_ready && (q.size() > 0);
        end
        @(posedge ACLK);
        if (ARESET) begin
            q.delete();
            ovf = 1'b0;
        end else if (do_flush) begin
            q.delete();
            ovf = 1'b0;
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(wdat);
            if (set_ovf) ovf = 1'b1;
        end
        #1;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        bus.m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = base + DW'(i);
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; CONTROL_i = 32'h0;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.s_data = '0;
        tick(); tick();
        vectors++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || fifo_empty_o !== 1'b1 ||
            fifo_full_o !== 1'b0 || fifo_level_o !== '0 || overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: rdy=%b vld=%b emp=%b full=%b lvl=%0d ovf=%b want 0 0 1 0 0 0",
                     bus.s_ready, bus.m_valid, fifo_empty_o, fifo_full_o, fifo_level_o, overflow_o);
        end
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        CONTROL_i = 32'h1;
        push_n(DEPTH, 32'hA0);
        #1;
        vectors++;
        if (fifo_full_o !== 1'b1 || fifo_level_o !== LW'(DEPTH)) begin
            miscompares++;
            $display("FAIL fill_full: full=%b lvl=%0d want 1 %0d", fifo_full_o, fifo_level_o, DEPTH);
        end
        bus.s_valid = 1'b1; bus.s_data = 32'hEE;
        #1;
        vectors++;
        if (bus.s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_sready: got %b want 0", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
        #1;
        vectors++;
        if (overflow_o !== 1'b1 || fifo_level_o !== LW'(DEPTH)) begin
            miscompares++;
            $display("FAIL fill_overflow: ovf=%b lvl=%0d want 1 %0d", overflow_o, fifo_level_o, DEPTH);
        end
    endtask

    task automatic test_drain();
        bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            vectors++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA0 + DW'(i)) begin
                miscompares++;
                $display("FAIL drain_data[%0d]: vld=%b data=%h want 1 %h", i, bus.m_valid, bus.m_data, 32'hA0 + i);
            end
            tick();
        end
        bus.m_ready = 1'b0;
        #1;
        vectors++;
        if (bus.m_valid !== 1'b0 || fifo_empty_o !== 1'b1 || fifo_level_o !== '0 || overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: vld=%b emp=%b lvl=%0d ovf=%b want 0 1 0 1",
                     bus.m_valid, fifo_empty_o, fifo_level_o, overflow_o);
        end
    endtask

    task automatic test_flush();
        push_n(7, 32'h70);
        CONTROL_i = 32'h3;
        tick();
        CONTROL_i = 32'h1;
        #1;
        vectors++;
        if (fifo_level_o !== '0 || fifo_empty_o !== 1'b1 || overflow_o !== 1'b0 || bus.m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: lvl=%0d emp=%b ovf=%b vld=%b want 0 1 0 0",
                     fifo_level_o, fifo_empty_o, overflow_o, bus.m_valid);
        end
        push_n(1, 32'h55);
        bus.m_ready = 1'b1;
        #1;
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h55) begin
            miscompares++;
            $display("FAIL flush_repush: vld=%b data=%h want 1 55", bus.m_valid, bus.m_data);
        end
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drain_all();
        push_n(5, 32'h500);
        bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.s_data = $urandom;
            #1;
            vectors++;
            if (fifo_level_o !== 32'd5 || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_data !== q[0]) begin
                miscompares++;
                $display("FAIL stream[%0d]: lvl=%0d vld=%b rdy=%b data=%h want 5 1 1 %h",
                         i, fifo_level_o, bus.m_valid, bus.s_ready, bus.m_data, q[0]);
            end
            tick();
        end
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    endtask

    task automatic test_disable();
        logic [DW-1:0] head;
        drain_all();
        push_n(4, 32'hD0);
        head = q[0];
        CONTROL_i = 32'h0;
        bus.s_valid = 1'b1; bus.m_ready = 1'b1; bus.s_data = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || fifo_level_o !== 32'd4) begin
                miscompares++;
                $display("FAIL disable_hold[%0d]: rdy=%b vld=%b lvl=%0d want 0 0 4",
                         i, bus.s_ready, bus.m_valid, fifo_level_o);
            end
            tick();
        end
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        CONTROL_i = 32'h1;
        #1;
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== head) begin
            miscompares++;
            $display("FAIL disable_resume: vld=%b data=%h want 1 %h", bus.m_valid, bus.m_data, head);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] first;
        drain_all();
        push_n(9, 32'h900);
        bus.s_valid = 1'b1; bus.s_data = 32'h999;
        #2;
        ARESET = 1'b1;
        #1;
        vectors++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || fifo_empty_o !== 1'b1 ||
            fifo_full_o !== 1'b0 || fifo_level_o !== '0 || overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b vld=%b emp=%b full=%b lvl=%0d ovf=%b want 0 0 1 0 0 0",
                     bus.s_ready, bus.m_valid, fifo_empty_o, fifo_full_o, fifo_level_o, overflow_o);
        end
        q.delete(); ovf = 1'b0;
        tick();
        ARESET = 1'b0;
        bus.s_valid = 1'b0;
        first = $urandom;
        push_n(1, first);
        push_n(3, 32'hC00);
        #1;
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== first || fifo_level_o !== 32'd4) begin
            miscompares++;
            $display("FAIL reset_refill: vld=%b data=%h lvl=%0d want 1 %h 4",
                     bus.m_valid, bus.m_data, fifo_level_o, first);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 29);
            CONTROL_i   = (r == 0) ? 32'h0 : (r == 1) ? 32'h3 : {$urandom} & 32'hFFFF_FFFC | 32'h1;
            bus.s_data  = $urandom;
            bus.s_valid = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bus.m_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (bus.s_ready !== exp_s_ready() || bus.m_valid !== exp_m_valid() ||
                fifo_empty_o !== (q.size() == 0) || fifo_full_o !== (q.size() == DEPTH) ||
                fifo_level_o !== LW'(q.size()) || overflow_o !== ovf ||
                (exp_m_valid() && bus.m_data !== q[0])) begin
                miscompares++;
                $display("FAIL random[%0d]: rdy=%b vld=%b emp=%b full=%b lvl=%0d ovf=%b data=%h want %b %b %b %b %0d %b %h",
                         i, bus.s_ready, bus.m_valid, fifo_empty_o, fifo_full_o, fifo_level_o, overflow_o, bus.m_data,
                         exp_s_ready(), exp_m_valid(), q.size() == 0, q.size() == DEPTH, q.size(), ovf,
                         (q.size() > 0) ? q[0] : '0);
            end
            tick();
        end
        bus.s_valid = 1'b0; bus.m_ready = 1'b0; CONTROL_i = 32'h1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_flush();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ctrl_sync_fifo.md
CTRL_SYNC_FIFO -- requirements
Module: ctrl_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter LEVEL_WIDTH, default 32, width of fifo_level_o, matching the CSR FIFO_LEVEL field.
REQ-004 SHALL have port ACLK, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port ARESET, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port CONTROL_i, input, 32, CSR CONTROL word: bit0 = EN, bit1 = FLUSH, others ignored.
REQ-007 SHALL have port s_data, input, DATA_WIDTH, write payload.
REQ-008 SHALL have port s_valid, input, 1, write request.
REQ-009 SHALL have port s_ready, output, 1, write accept.
REQ-010 SHALL have port m_data, output, DATA_WIDTH, head-of-queue payload.
REQ-011 SHALL have port m_valid, output, 1, head valid.
REQ-012 SHALL have port m_ready, input, 1, read accept.
REQ-013 SHALL have port fifo_empty_o, output, 1, level == 0.
REQ-014 SHALL have port fifo_full_o, output, 1, level == DEPTH.
REQ-015 SHALL have port fifo_level_o, output, LEVEL_WIDTH, occupancy, zero-extended.
REQ-016 SHALL have port overflow_o, output, 1, sticky flag: write attempted while full.

Function
REQ-017 Push SHALL occur when s_valid && s_ready; s_ready = EN && !FLUSH && !full.
REQ-018 Pop SHALL occur when m_valid && m_ready; m_valid = EN && !FLUSH && !empty.
REQ-019 Data SHALL be first-word-fall-through: m_data shows the oldest entry combinationally from memory whenever the FIFO is non-empty.
REQ-020 Write and read pointers SHALL be log2(DEPTH)+1 bits wide. Empty is pointer equality. Full is equal index bits with differing MSB. Wrap-around is natural binary rollover.
REQ-021 Level SHALL be registered: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
REQ-022 Flags and level SHALL update in the cycle after the causing handshake (1-cycle latency).
REQ-023 Push and pop in the same cycle SHALL be legal at any level from 1 to DEPTH-1.
REQ-024 Push to an empty FIFO SHALL NOT bypass: m_valid rises one cycle after the push.
REQ-025 When full, push SHALL be impossible, because s_ready = 0.
REQ-026 When empty, pop SHALL be impossible, because m_valid = 0.
REQ-027 When EN = 0, contents, pointers and level SHALL be held; s_ready = 0 and m_valid = 0.
REQ-028 While FLUSH = 1, both pointers and the level SHALL be cleared on every edge, empty = 1, and overflow_o SHALL be cleared. FLUSH SHALL take priority over EN and over any handshake. Memory contents SHALL not be cleared.
REQ-029 overflow_o SHALL be set on any cycle with s_valid && EN && !FLUSH && full, and SHALL hold until FLUSH or reset.
REQ-030 Flags and level SHALL be mutually consistent every cycle: empty ⇔ level == 0; full ⇔ level == DEPTH.

Reset
REQ-031 ARESET SHALL asynchronously clear pointers, level and overflow_o.
REQ-032 Reset values SHALL be: s_ready = 0, m_valid = 0, fifo_empty_o = 1, fifo_full_o = 0, fifo_level_o = 0, overflow_o = 0. m_data is don't-care.
REQ-033 Storage memory SHALL NOT be reset.
REQ-034 Reset asserted mid-transfer SHALL discard all entries; the first post-reset pop SHALL return the first post-reset push.

Structure
REQ-035 Package ctrl_fifo_pkg SHALL hold CTRL_EN_BIT = 0, CTRL_FLUSH_BIT = 1, and the CSR-shared LEVEL_WIDTH default.
REQ-036 Storage SHALL be a sub-module fifo_ram with a simple dual-port array: synchronous write, asynchronous read, no reset.
REQ-037 Pointer, flag and level logic SHALL reside in ctrl_sync_fifo.

Verification (DEPTH = 16)
REQ-038 Reset, then CONTROL_i = 0x1, push 0xA0..0xAF -> full = 1 and level = 16 the cycle after the 16th push; a 17th s_valid sets overflow_o = 1 and leaves level = 16.
REQ-039 From full, pop 16 -> data 0xA0..0xAF in order; empty = 1 and level = 0; m_valid = 0 after the last pop.
REQ-040 Level 5 with push and pop every cycle for 40 cycles -> level stays 5, data stays in order, pointers wrap without error.
REQ-041 Level 7, CONTROL_i = 0x3 for 1 cycle then 0x1 -> level = 0, empty = 1, overflow_o = 0; the next push of 0x55 is popped as 0x55.
REQ-042 Level 4, CONTROL_i = 0x0 with s_valid and m_ready held high -> s_ready = 0, m_valid = 0, level stays 4; restoring 0x1 resumes with the original head.
REQ-043 ARESET pulsed at level 9 during a push -> all outputs take reset values immediately; the next pop after refill returns the first post-reset data.
